// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - Hack-style control/register stage around an external 8-bit ALU.
module hack_cpu_ctrl #(
    parameter int WIDTH = 8,
    parameter int PC_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instr,
    output logic [PC_W-1:0]  pc,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] out_m,
    output logic             write_m,
    output logic [PC_W-1:0]  address_m,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic             exec
);

    typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;

    state_t           state, state_nx;
    logic [15:0]      ir;
    logic [WIDTH-1:0] a_reg, d_reg;
    logic             is_c, in_exec, mem_acc, done, jump;
    logic [1:0]       unused_ir;

    assign is_c      = ir[15];
    assign in_exec   = (state == S_EXEC);
    assign unused_ir = ir[14:13];

    // A C-instruction touching memory (read via a, write via dest M) must wait for mem_ready.
    assign mem_acc = is_c & (ir[12] | ir[3]);
    assign done    = in_exec & (~mem_acc | mem_ready);
    assign jump    = is_c & ((ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr));

    assign alu_x     = d_reg;
    assign alu_y     = (is_c & ir[12]) ? in_m : a_reg;
    assign out_m     = alu_out;
    assign address_m = a_reg[PC_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: state_nx = S_EXEC;
            S_EXEC:  if (done) state_nx = S_FETCH;
            default: state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        exec    = in_exec;
        write_m = in_exec & is_c & ir[3];
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = (in_exec & is_c) ? ir[11:6] : 6'b0;
    end

    // Jump target and address_m both use A as it was before this instruction's writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir    <= '0;
            a_reg <= '0;
            d_reg <= '0;
            pc    <= '0;
        end else if (state == S_FETCH) begin
            ir <= instr;
        end else if (done) begin
            if (!is_c) begin
                a_reg <= ir[WIDTH-1:0];
            end else begin
                if (ir[5]) a_reg <= alu_out;
                if (ir[4]) d_reg <= alu_out;
            end
            pc <= jump ? a_reg[PC_W-1:0] : pc + PC_W'(1);
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb/tb_hack_cpu_ctrl.sv - Self-checking bench for hack_cpu_ctrl with an instruction-level model.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr;
    logic [7:0]  pc, in_m, out_m, address_m, alu_x, alu_y, alu_out;
    logic        write_m, mem_ready = 1'b1, exec;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

    logic [15:0] rom  [256];
    logic [7:0]  ram  [256];
    logic [7:0]  mram [256];

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;
    logic wm_seen = 1'b0;

    hack_cpu_ctrl #(.WIDTH(8), .PC_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .pc(pc), .in_m(in_m), .out_m(out_m),
        .write_m(write_m), .address_m(address_m), .mem_ready(mem_ready),
        .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out),
        .alu_zr(alu_zr), .alu_ng(alu_ng), .exec(exec)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hack_alu(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
        logic [7:0] xx, yy, o;
        xx = c[5] ? 8'h00 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 8'h00 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? xx + yy : xx & yy;
        if (c[0]) o = ~o;
        return o;
    endfunction

    // Environment: program ROM, data RAM and the ALU itself.
    assign instr   = rom[pc];
    assign in_m    = ram[address_m];
    assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 8'h00);
    assign alu_ng  = alu_out[7];

    always @(posedge clk) begin
        if (!reset && write_m && mem_ready) ram[address_m] <= out_m;
    end

    always @(negedge clk) begin
        if (!reset && write_m) wm_seen <= 1'b1;
    end

    // Instruction-level reference: one instruction = fetch cycle + exec cycle(s).
    logic        m_exec;
    logic [15:0] m_ir;
    logic [7:0]  m_A, m_D, m_pc, m_r, m_y;
    logic        m_jump;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_exec = 1'b0; m_ir = 16'h0; m_A = 8'h0; m_D = 8'h0; m_pc = 8'h0;
        end else if (!m_exec) begin
            m_ir   = rom[m_pc];
            m_exec = 1'b1;
        end else if (!m_ir[15]) begin
            m_A    = m_ir[7:0];
            m_pc   = m_pc + 8'd1;
            m_exec = 1'b0;
        end else if (!(m_ir[12] || m_ir[3]) || mem_ready) begin
            m_y    = m_ir[12] ? mram[m_A] : m_A;
            m_r    = hack_alu(m_D, m_y, m_ir[11:6]);
            m_jump = (m_ir[2] && m_r[7]) || (m_ir[1] && m_r == 8'h00) ||
                     (m_ir[0] && !m_r[7] && m_r != 8'h00);
            if (m_ir[3]) mram[m_A] = m_r;
            m_pc   = m_jump ? m_A : m_pc + 8'd1;
            if (m_ir[5]) m_A = m_r;
            if (m_ir[4]) m_D = m_r;
            m_exec = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_c;
        if (!reset && chk_en) begin
            exp_c = m_exec && m_ir[15];
            check("exec", 32'(exec), 32'(m_exec));
            check("pc", 32'(pc), 32'(m_pc));
            check("address_m", 32'(address_m), 32'(m_A));
            check("alu_x", 32'(alu_x), 32'(m_D));
            check("write_m", 32'(write_m), 32'(exp_c && m_ir[3]));
            check("alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
                  32'(exp_c ? m_ir[11:6] : 6'b0));
            if (exp_c) begin
                check("alu_y", 32'(alu_y), 32'(m_ir[12] ? mram[m_A] : m_A));
                check("out_m", 32'(out_m),
                      32'(hack_alu(m_D, m_ir[12] ? mram[m_A] : m_A, m_ir[11:6])));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 16'h0000;
            v       = 8'($urandom);
            ram[i] <= v;
            mram[i] = v;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset   = 1'b0;
        wm_seen = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        if ($urandom_range(1, 0) == 1) return {1'b1, 15'($urandom)};
        return {1'b0, 15'($urandom)};
    endfunction

    initial begin
        int wcnt, ecnt;
        clear_mem();
        chk_en = 1'b1;

        // Load and subtract, then a memory write and a stalled memory write.
        rom[0] = 16'd17; rom[1] = 16'hEC10; rom[2] = 16'd6; rom[3] = 16'hE4D0;
        rom[4] = 16'd9;  rom[5] = 16'hE308; rom[6] = 16'hE308;
        reset = 1'b1;
        #3;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_exec", 32'(exec), 32'd0);
        check("reset_write_m", 32'(write_m), 32'd0);
        check("reset_D", 32'(alu_x), 32'd0);
        do_reset();
        cycles(8);
        check("sub_D", 32'(alu_x), 32'd11);
        check("sub_A", 32'(address_m), 32'd6);
        check("sub_pc", 32'(pc), 32'd4);
        check("sub_no_write", 32'(wm_seen), 32'd0);
        cycles(3);
        check("mw_write_m", 32'(write_m), 32'd1);
        check("mw_addr", 32'(address_m), 32'd9);
        check("mw_out_m", 32'(out_m), 32'd11);
        cycles(1);
        check("mw_pc", 32'(pc), 32'd6);
        check("mw_ram", 32'(ram[9]), 32'd11);
        #2 mem_ready = 1'b0;
        cycles(1);
        wcnt = 0; ecnt = 0;
        for (int i = 0; i < 4; i++) begin
            wcnt += int'(write_m);
            ecnt += int'(exec);
            check("stall_pc", 32'(pc), 32'd6);
            if (i == 3) begin
                #2 mem_ready = 1'b1;
            end
            cycles(1);
        end
        check("stall_write_cycles", 32'(wcnt), 32'd4);
        check("stall_exec_cycles", 32'(ecnt), 32'd4);
        check("stall_pc_after", 32'(pc), 32'd7);
        check("stall_exec_after", 32'(exec), 32'd0);

        // Jumps: D=0;JEQ taken, D=3;JEQ not taken, D=-1;JLT taken.
        clear_mem();
        rom[0] = 16'hEA90; rom[1] = 16'd5; rom[2] = 16'hE302;
        do_reset();
        cycles(6);
        check("jeq_taken_pc", 32'(pc), 32'd5);
        clear_mem();
        rom[0] = 16'd3; rom[1] = 16'hEC10; rom[2] = 16'd5; rom[3] = 16'hE302;
        do_reset();
        cycles(8);
        check("jeq_not_taken_pc", 32'(pc), 32'd4);
        clear_mem();
        rom[0] = 16'hEE90; rom[1] = 16'd5; rom[2] = 16'hE304;
        do_reset();
        cycles(6);
        check("jlt_D", 32'(alu_x), 32'hFF);
        check("jlt_taken_pc", 32'(pc), 32'd5);

        // Reset asserted in the middle of an EXEC of D=D+1.
        clear_mem();
        rom[0] = 16'd7; rom[1] = 16'hE7D0; rom[2] = 16'hE7D0;
        do_reset();
        cycles(4);
        check("inc_D", 32'(alu_x), 32'd1);
        cycles(1);
        check("inc_in_exec", 32'(exec), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_D", 32'(alu_x), 32'd0);
        check("abort_A", 32'(address_m), 32'd0);
        check("abort_write_m", 32'(write_m), 32'd0);
        check("abort_exec", 32'(exec), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        cycles(1);
        check("post_reset_exec", 32'(exec), 32'd1);
        check("post_reset_pc", 32'(pc), 32'd0);

        // PC wrap and A-instruction truncation.
        clear_mem();
        rom[0] = 16'h00FF; rom[1] = 16'hEA87; rom[255] = 16'h01F3;
        do_reset();
        cycles(4);
        check("wrap_pc_255", 32'(pc), 32'd255);
        cycles(2);
        check("wrap_pc_0", 32'(pc), 32'd0);
        check("trunc_A", 32'(address_m), 32'hF3);

        // Random programs with random memory stalls.
        for (int r = 0; r < 4; r++) begin
            clear_mem();
            for (int i = 0; i < 256; i++) rom[i] = rand_instr();
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                #2 mem_ready = ($urandom_range(3, 0) != 0);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
